// File: rtl/wrr_pop_scheduler.sv
// wrr_pop_scheduler: weighted round-robin pop scheduler draining per-requester FIFOs into one consumer
module wrr_pop_scheduler #(
    parameter int NUM_REQS = 4,
    parameter int WWID     = 4,
    parameter int IDXWID   = $clog2(NUM_REQS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQS-1:0]      empty,
    input  logic [NUM_REQS*WWID-1:0] weights,
    input  logic                     out_rdy,
    input  logic                     blk,
    output logic [NUM_REQS-1:0]      pop,
    output logic [NUM_REQS-1:0]      gnt,
    output logic [IDXWID-1:0]        gnt_idx,
    output logic [WWID-1:0]          credit,
    output logic                     busy
);
    typedef enum logic {IDLE, SERVE} state_t;
    state_t state, state_nxt;
    logic [IDXWID-1:0] ptr, ptr_nxt, cur, cur_nxt, sel, cur_inc;
    logic [WWID-1:0] credit_nxt, sel_w;
    logic found, fire, done;
    int j;
    always_comb begin
        found = 1'b0;
        sel = ptr;
        j = 0;
        for (int k = 0; k < NUM_REQS; k++) begin
            j = (int'(ptr) + k) % NUM_REQS;
            if (!found && !empty[j]) begin
                found = 1'b1;
                sel = IDXWID'(j);
            end
        end
    end
    assign sel_w   = weights[int'(sel)*WWID +: WWID];
    assign cur_inc = (int'(cur) == NUM_REQS-1) ? '0 : cur + 1'b1;
    assign busy    = state == SERVE;
    assign fire    = busy && !empty[cur] && out_rdy && !blk;
    assign done    = busy && (empty[cur] || (fire && credit == WWID'(1)));
    assign pop     = fire ? NUM_REQS'(1) << cur : '0;
    assign gnt     = busy ? NUM_REQS'(1) << cur : '0;
    assign gnt_idx = cur;
    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        cur_nxt    = cur;
        credit_nxt = credit;
        if (!busy && found) begin
            state_nxt  = SERVE;
            cur_nxt    = sel;
            credit_nxt = (sel_w == '0) ? WWID'(1) : sel_w;
        end else if (done) begin
            state_nxt  = IDLE;
            ptr_nxt    = cur_inc;
            credit_nxt = '0;
        end else if (fire) begin
            credit_nxt = credit - 1'b1;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            ptr    <= '0;
            cur    <= '0;
            credit <= '0;
        end else begin
            state  <= state_nxt;
            ptr    <= ptr_nxt;
            cur    <= cur_nxt;
            credit <= credit_nxt;
        end
    end
endmodule
